// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use stall, branch/jump flush and memory-wait control.
// Optional HAZ_PERF_COUNT_EN adds stall_cycles/flush_count performance counters.
module if_id_hazard_stage #(
    parameter int          WAIT_MAX = 16,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc_mais_4,
    input  logic        mem_ready,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        pcsrc,
    input  logic        jump,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc_mais_4,
    output logic        id_valid,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        HazMuxCon,
    output logic        mem_timeout,
    output logic [1:0]  state_dbg
`ifdef HAZ_PERF_COUNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    // Handshake: mem_ready is the valid of if_inst for the current cycle; PCWrite is the
    // fetch-side ready. A word is consumed only on a cycle where both are high.

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_LDUSE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_FLUSH  = 2'd2,
        ACT_BUBBLE = 2'd3
    } act_t;

    localparam logic [7:0] WAIT_MAX_W = 8'(WAIT_MAX);

    state_t     state_q;
    state_t     state_d;
    act_t       act;
    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_inc;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       hazard;
    logic       redirect;

    assign id_rs        = id_inst[25:21];
    assign id_rt        = id_inst[20:16];
    assign hazard       = id_valid & ex_mem_read & (ex_rt != 5'd0) &
                          ((ex_rt == id_rs) | (ex_rt == id_rt));
    assign redirect     = pcsrc | jump;
    assign wait_cnt_inc = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // The hazard term is only honoured in RUN: in LDUSE the load has moved on, and in
    // WAIT the IF/ID slot always holds a bubble.
    always_comb begin
        act     = ACT_LOAD;
        state_d = S_RUN;
        if ((state_q == S_RUN) && hazard) begin
            act     = ACT_HOLD;
            state_d = S_LDUSE;
        end else if (redirect) begin
            act     = ACT_FLUSH;
            state_d = S_RUN;
        end else if (!mem_ready) begin
            act     = ACT_BUBBLE;
            state_d = S_WAIT;
        end
    end

    always_comb begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        HazMuxCon = 1'b0;
        state_dbg = state_q;
        if (!reset) begin
            PCWrite   = (act == ACT_LOAD) || (act == ACT_FLUSH);
            IFIDWrite = (act != ACT_HOLD);
            HazMuxCon = (act != ACT_HOLD);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            id_inst      <= NOP_WORD;
            id_pc_mais_4 <= 32'd0;
            id_valid     <= 1'b0;
            wait_cnt_q   <= 8'd0;
            mem_timeout  <= 1'b0;
        end else begin
            unique case (act)
                ACT_LOAD: begin
                    id_inst      <= if_inst;
                    id_pc_mais_4 <= if_pc_mais_4;
                    id_valid     <= 1'b1;
                    wait_cnt_q   <= 8'd0;
                end
                ACT_HOLD: begin
                    wait_cnt_q <= 8'd0;
                end
                ACT_FLUSH: begin
                    id_inst      <= NOP_WORD;
                    id_pc_mais_4 <= 32'd0;
                    id_valid     <= 1'b0;
                    wait_cnt_q   <= 8'd0;
                end
                ACT_BUBBLE: begin
                    id_inst      <= NOP_WORD;
                    id_pc_mais_4 <= 32'd0;
                    id_valid     <= 1'b0;
                    wait_cnt_q   <= wait_cnt_inc;
                    if (wait_cnt_inc >= WAIT_MAX_W) begin
                        mem_timeout <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef HAZ_PERF_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (!PCWrite) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (act == ACT_FLUSH) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule
